// File: rtl/mvu_bin_packer.sv
// Binarizing packer: turns a stream of signed accumulator values into SIMD-bit
// words (1 = value >= 0, 0 = negative), closing a word early on in_last.
module mvu_bin_packer #(
   parameter int TDstI = 16,
   parameter int SIMD  = 4
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             in_v,
   input  logic [TDstI-1:0] in_d,
   input  logic             in_last,
   output logic             in_rdy,
   output logic             out_v,
   output logic [SIMD-1:0]  out_d,
   output logic             out_last,
   input  logic             out_rdy
);

   localparam int CW = (SIMD > 1) ? $clog2(SIMD) : 1;

   logic [SIMD-1:0] r_asm;
   logic [CW-1:0]   r_cnt;
   logic            r_out_v;
   logic [SIMD-1:0] r_out_d;
   logic            r_out_last;

   logic            w_in_rdy;
   logic            w_accept;
   logic            w_xfer;
   logic            w_bit;
   logic            w_close;
   logic [SIMD-1:0] w_word;

   // Only a word stalled at the output blocks the input; a word leaving this
   // cycle frees the register in time for the next completion.
   assign w_in_rdy = ~(r_out_v & ~out_rdy);
   assign w_accept = in_v & w_in_rdy;
   assign w_xfer   = r_out_v & out_rdy;
   assign w_bit    = ~in_d[TDstI-1];
   assign w_close  = (r_cnt == CW'(SIMD - 1)) | in_last;
   // Slots above r_cnt are still zero in r_asm, so an early close zero-fills.
   assign w_word   = r_asm | (w_bit ? (SIMD'(1) << r_cnt) : '0);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values; later assignments (the completion) override the
   // earlier out_v clear when both happen on the same edge.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_asm      <= '0;
         r_cnt      <= '0;
         r_out_v    <= 1'b0;
         r_out_d    <= '0;
         r_out_last <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_out_v <= 1'b0;
         end
         if (w_accept) begin
            if (w_close) begin
               r_out_d    <= w_word;
               r_out_v    <= 1'b1;
               r_out_last <= in_last;
               r_asm      <= '0;
               r_cnt      <= '0;
            end else begin
               r_asm <= w_word;
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign in_rdy   = w_in_rdy;
   assign out_v    = r_out_v;
   assign out_d    = r_out_d;
   assign out_last = r_out_last;

endmodule

// File: tb/tb_mvu_bin_packer.sv
// Directed and randomized checks of mvu_bin_packer: a SIMD=4 instance for packing,
// backpressure, flush and reset, plus a SIMD=1 instance for full-rate streaming.
module tb_mvu_bin_packer;

   localparam int TD = 8;
   localparam int SW = 4;

   logic                 aclk = 1'b0;
   logic                 aresetn;
   logic                 in_v, in_last, in_rdy, out_v, out_last, out_rdy;
   logic signed [TD-1:0] in_d;
   logic [SW-1:0]        out_d;

   logic                 s_in_v, s_in_last, s_in_rdy, s_out_v, s_out_last, s_out_rdy;
   logic signed [TD-1:0] s_in_d;
   logic [0:0]           s_out_d;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model state for the randomized run
   logic          m_out_v;
   logic [SW-1:0] m_asm;
   int            m_cnt;
   int            n_acc;
   logic [SW:0]   q_exp[$];

   always #5 aclk = ~aclk;

   mvu_bin_packer #(.TDstI(TD), .SIMD(SW)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_v(in_v), .in_d(in_d), .in_last(in_last), .in_rdy(in_rdy),
      .out_v(out_v), .out_d(out_d), .out_last(out_last), .out_rdy(out_rdy)
   );

   mvu_bin_packer #(.TDstI(TD), .SIMD(1)) u_dut1 (
      .aclk(aclk), .aresetn(aresetn),
      .in_v(s_in_v), .in_d(s_in_d), .in_last(s_in_last), .in_rdy(s_in_rdy),
      .out_v(s_out_v), .out_d(s_out_d), .out_last(s_out_last), .out_rdy(s_out_rdy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic signed [TD-1:0] d, input logic l);
      chk("in_rdy_at_send", in_rdy, 1);
      in_v    = 1'b1;
      in_d    = d;
      in_last = l;
      tick();
      in_v    = 1'b0;
      in_d    = 'x;
      in_last = 1'b0;
   endtask

   // One clock of the randomized run using whatever inputs are currently driven
   task automatic model_cycle();
      logic       xfer, acc;
      logic [SW:0] e;
      #1;
      chk("rnd_in_rdy", in_rdy, !(m_out_v && !out_rdy));
      xfer = m_out_v && out_rdy;
      acc  = in_v && !(m_out_v && !out_rdy);
      if (xfer) begin
         chk("rnd_queue_nonempty", (q_exp.size() > 0), 1);
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("rnd_word", {out_last, out_d}, e);
         end
         m_out_v = 1'b0;
      end
      if (acc) begin
         n_acc++;
         m_asm[m_cnt] = (in_d >= 0);
         if (m_cnt == SW - 1 || in_last) begin
            q_exp.push_back({in_last, m_asm});
            m_out_v = 1'b1;
            m_asm   = '0;
            m_cnt   = 0;
         end else begin
            m_cnt++;
         end
      end
      @(posedge aclk);
      #1;
      chk("rnd_out_v", out_v, m_out_v);
   endtask

   initial begin
      aresetn   = 1'b0;
      in_v      = 1'b0;
      in_d      = '0;
      in_last   = 1'b0;
      out_rdy   = 1'b1;
      s_in_v    = 1'b0;
      s_in_d    = '0;
      s_in_last = 1'b0;
      s_out_rdy = 1'b1;
      tick();
      tick();
      chk("rst_out_v", out_v, 0);
      chk("rst_out_d", out_d, 0);
      chk("rst_out_last", out_last, 0);
      aresetn = 1'b1;
      chk("rst_in_rdy", in_rdy, 1);

      // Basic pack: 5,-3,0,-128 -> 0101
      send(8'sd5, 1'b0);
      send(-8'sd3, 1'b0);
      send(8'sd0, 1'b0);
      chk("basic_not_yet_valid", out_v, 0);
      send(-8'sd128, 1'b0);
      chk("basic_out_v", out_v, 1);
      chk("basic_out_d", out_d, 4'b0101);
      chk("basic_out_last", out_last, 0);
      tick();
      chk("basic_drained", out_v, 0);
      chk("basic_d_held", out_d, 4'b0101);

      // Backpressure: 1,1,-1,-1 -> 0011 held while stalled
      out_rdy = 1'b0;
      send(8'sd1, 1'b0);
      send(8'sd1, 1'b0);
      send(-8'sd1, 1'b0);
      send(-8'sd1, 1'b0);
      chk("bp_out_v", out_v, 1);
      chk("bp_out_d", out_d, 4'b0011);
      chk("bp_in_rdy_low", in_rdy, 0);
      in_v = 1'b1;
      in_d = -8'sd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_v", out_v, 1);
         chk("bp_hold_d", out_d, 4'b0011);
         chk("bp_hold_rdy", in_rdy, 0);
      end
      out_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", in_rdy, 1);
      tick();
      in_v = 1'b0;
      in_d = 'x;
      chk("bp_transferred", out_v, 0);
      // -5 was taken into slot 0 on the release edge
      send(8'sd3, 1'b0);
      send(8'sd3, 1'b0);
      send(8'sd3, 1'b0);
      chk("bp_next_v", out_v, 1);
      chk("bp_next_d", out_d, 4'b1110);
      tick();

      // Early flush: 7, -1(last) -> 0001 last; next word restarts at bit 0
      send(8'sd7, 1'b0);
      send(-8'sd1, 1'b1);
      chk("flush_v", out_v, 1);
      chk("flush_d", out_d, 4'b0001);
      chk("flush_last", out_last, 1);
      send(-8'sd2, 1'b0);
      send(8'sd4, 1'b1);
      chk("flush2_v", out_v, 1);
      chk("flush2_d", out_d, 4'b0010);
      chk("flush2_last", out_last, 1);
      tick();

      // Reset mid-word discards the partial bits
      send(8'sd1, 1'b0);
      send(8'sd1, 1'b0);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      chk("midrst_out_v", out_v, 0);
      chk("midrst_in_rdy", in_rdy, 1);
      send(-8'sd1, 1'b0);
      send(-8'sd1, 1'b0);
      send(-8'sd1, 1'b0);
      chk("midrst_no_word", out_v, 0);
      send(8'sd2, 1'b0);
      chk("midrst_v", out_v, 1);
      chk("midrst_d", out_d, 4'b1000);
      chk("midrst_last", out_last, 0);
      tick();

      // SIMD=1 streaming at full rate
      for (int i = 0; i < 8; i++) begin
         chk("s1_in_rdy", s_in_rdy, 1);
         s_in_v = 1'b1;
         s_in_d = (i % 2 == 0) ? 8'sd1 : -8'sd1;
         tick();
         chk("s1_out_v", s_out_v, 1);
         chk("s1_out_d", s_out_d, (i % 2 == 0) ? 1 : 0);
      end
      s_in_v = 1'b0;
      tick();
      chk("s1_idle", s_out_v, 0);

      // Randomized traffic against the scoreboard model
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      m_out_v = 1'b0;
      m_asm   = '0;
      m_cnt   = 0;
      n_acc   = 0;
      for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
         in_v    = ($urandom_range(0, 3) != 0);
         in_d    = TD'($urandom_range(0, 255));
         in_last = ($urandom_range(0, 7) == 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         model_cycle();
      end
      chk("rnd_accepted", n_acc, 1000);
      in_v    = 1'b0;
      in_d    = 'x;
      in_last = 1'b0;
      out_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         model_cycle();
      end
      chk("rnd_queue_empty", q_exp.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
